trig_pulse_gen: RTL and testbench

- Generates a programmable-width trigger pulse on `signal_o` from a single-cycle request on `start_i`.
- Enforces a programmable minimum low gap after each pulse.
- Forms the transmit end of the trigger line whose receive end is the edge-detector FSM: downstream edge detection sees exactly one rising edge per accepted request.
- Sits between a control/sequencer block and any edge-triggered consumer.

---
 rtl/trig_pkg.sv | 10 +
 rtl/trig_down_cnt.sv | 26 ++
 rtl/trig_pulse_gen.sv | 122 ++++++++++++
 tb/tb_trig_pulse_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared definitions for the trigger pulse generator: FSM state codes and default counter width.
package trig_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/trig_down_cnt.sv
// Loadable down-counter with zero flag; shared by the HIGH and GAP phases of the pulse FSM.
module trig_down_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    assign zero = (cnt == '0);

    // Decrement is gated on a non-zero count so the counter can never wrap.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - W'(1);
    end

endmodule

// File: rtl/trig_pulse_gen.sv
// Programmable-width trigger pulse with enforced minimum low gap.
// Optional one-deep request queue enabled by defining TRIG_PULSE_GEN_QUEUE_EN.
module trig_pulse_gen
    import trig_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [CNT_W-1:0] gap_i,
    output logic             signal_o,
    output logic             busy_o,
    output logic             done_o
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] cnt, ld_val;
    logic             cnt_zero, cnt_ld, cnt_dec;
    logic             acc, done_d;
    logic             req_v;
    logic [CNT_W-1:0] req_len, req_gap, eff_len;

`ifdef TRIG_PULSE_GEN_QUEUE_EN
    logic             pend_v;
    logic [CNT_W-1:0] pend_len, pend_gap;

    // A fresh strobe in IDLE is newer than anything parked, so it takes priority.
    assign req_v   = start_i || pend_v;
    assign req_len = start_i ? len_i : pend_len;
    assign req_gap = start_i ? gap_i : pend_gap;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v   <= 1'b0;
            pend_len <= '0;
            pend_gap <= '0;
        end else if (acc) begin
            pend_v   <= 1'b0;
        end else if (start_i && state_q != ST_IDLE) begin
            pend_v   <= 1'b1;
            pend_len <= len_i;
            pend_gap <= gap_i;
        end
    end
`else
    assign req_v   = start_i;
    assign req_len = len_i;
    assign req_gap = gap_i;
`endif

    assign eff_len = (req_len == '0) ? CNT_W'(1) : req_len;
    assign busy_o  = (state_q != ST_IDLE);

    trig_down_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_ld),
        .load_val (ld_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_ld  = 1'b0;
        cnt_dec = 1'b0;
        ld_val  = eff_len - CNT_W'(1);
        acc     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_v) begin
                    acc     = 1'b1;
                    cnt_ld  = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    done_d = 1'b1;
                    if (gap_q != '0) begin
                        cnt_ld  = 1'b1;
                        ld_val  = gap_q - CNT_W'(1);
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (!cnt_zero)
                    cnt_dec = 1'b1;
                else
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the line tracks the FSM without a lag cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            signal_o <= 1'b0;
            done_o   <= 1'b0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            signal_o <= (state_d == ST_HIGH);
            done_o   <= done_d;
            if (acc)
                gap_q <= req_gap;
        end
    end

endmodule

// File: tb/tb_trig_pulse_gen.sv
// Directed self-checking bench for trig_pulse_gen; queue scenario follows TRIG_PULSE_GEN_QUEUE_EN.
module tb_trig_pulse_gen;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [CNT_W-1:0] len_i, gap_i;
    logic             signal_o, busy_o, done_o;

    int n_chk  = 0;
    int n_fail = 0;

    trig_pulse_gen #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .len_i    (len_i),
        .gap_i    (gap_i),
        .signal_o (signal_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; len_i = 8'd3; gap_i = 8'd2;
        step(); step();
        n_chk++; if (signal_o !== 1'b0) begin n_fail++; $display("FAIL reset_signal got=%b exp=0", signal_o); end
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_chk++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        start_i = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] exp_sig, exp_busy, exp_done;
        exp_sig  = 8'b0000_0111;
        exp_done = 8'b0000_1000;
        exp_busy = 8'b0001_1111;
        start_i = 1'b1; len_i = 8'd3; gap_i = 8'd2;
        for (int j = 0; j < 8; j++) begin
            step();
            start_i = 1'b0; len_i = 8'd9; gap_i = 8'd9;
            n_chk++; if (signal_o !== exp_sig[j]) begin n_fail++; $display("FAIL basic_signal j=%0d got=%b exp=%b", j+1, signal_o, exp_sig[j]); end
            n_chk++; if (busy_o !== exp_busy[j]) begin n_fail++; $display("FAIL basic_busy j=%0d got=%b exp=%b", j+1, busy_o, exp_busy[j]); end
            n_chk++; if (done_o !== exp_done[j]) begin n_fail++; $display("FAIL basic_done j=%0d got=%b exp=%b", j+1, done_o, exp_done[j]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_sig, exp_done;
        exp_sig  = 4'b0101;
        exp_done = 4'b1010;
        for (int j = 0; j < 4; j++) begin
            start_i = (j == 0 || j == 2); len_i = 8'd0; gap_i = 8'd0;
            step();
            n_chk++; if (signal_o !== exp_sig[j]) begin n_fail++; $display("FAIL b2b_signal j=%0d got=%b exp=%b", j+1, signal_o, exp_sig[j]); end
            n_chk++; if (done_o !== exp_done[j]) begin n_fail++; $display("FAIL b2b_done j=%0d got=%b exp=%b", j+1, done_o, exp_done[j]); end
            n_chk++; if (busy_o !== exp_sig[j]) begin n_fail++; $display("FAIL b2b_busy j=%0d got=%b exp=%b", j+1, busy_o, exp_sig[j]); end
        end
        start_i = 1'b0;
        step(); step();
    endtask

    task automatic test_held_start();
        logic [11:0] exp_sig, exp_busy;
        int rises;
        logic prev;
        exp_sig  = 12'b0011_0011_0011;
        exp_busy = 12'b0111_0111_0111;
        rises = 0; prev = 1'b0;
        start_i = 1'b1; len_i = 8'd2; gap_i = 8'd1;
        for (int j = 0; j < 12; j++) begin
            step();
            if (signal_o && !prev) rises++;
            prev = signal_o;
            n_chk++; if (signal_o !== exp_sig[j]) begin n_fail++; $display("FAIL held_signal j=%0d got=%b exp=%b", j+1, signal_o, exp_sig[j]); end
            n_chk++; if (busy_o !== exp_busy[j]) begin n_fail++; $display("FAIL held_busy j=%0d got=%b exp=%b", j+1, busy_o, exp_busy[j]); end
        end
        n_chk++; if (rises !== 3) begin n_fail++; $display("FAIL held_rises got=%0d exp=3", rises); end
        start_i = 1'b0;
        for (int j = 0; j < 6; j++) step();
    endtask

    task automatic test_rst_mid();
        int dones;
        start_i = 1'b1; len_i = 8'd5; gap_i = 8'd3;
        step();
        start_i = 1'b0;
        step();
        n_chk++; if (signal_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b exp=1", signal_o); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++; if (signal_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_signal got=%b exp=0", signal_o); end
        n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
        n_chk++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got=%b exp=0", done_o); end
        dones = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (done_o || signal_o || busy_o) dones++;
        end
        n_chk++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_after got=%0d active cycles exp=0", dones); end
    endtask

    task automatic test_max();
        int hi, bz, dn, first_lo;
        hi = 0; bz = 0; dn = 0; first_lo = 0;
        start_i = 1'b1; len_i = 8'd255; gap_i = 8'd255;
        for (int j = 1; j <= 520; j++) begin
            step();
            start_i = 1'b0;
            if (signal_o) hi++;
            if (busy_o) bz++;
            if (done_o) dn++;
            if (!signal_o && first_lo == 0) first_lo = j;
        end
        n_chk++; if (hi !== 255) begin n_fail++; $display("FAIL max_high got=%0d exp=255", hi); end
        n_chk++; if (bz !== 510) begin n_fail++; $display("FAIL max_busy got=%0d exp=510", bz); end
        n_chk++; if (dn !== 1) begin n_fail++; $display("FAIL max_done got=%0d exp=1", dn); end
        n_chk++; if (first_lo !== 256) begin n_fail++; $display("FAIL max_first_low got=%0d exp=256", first_lo); end
    endtask

    // Start len=4/gap=2, then two more starts while HIGH (len=6 then len=2/gap=1).
    task automatic test_busy_start();
        logic [13:0] exp_sig, exp_done;
`ifdef TRIG_PULSE_GEN_QUEUE_EN
        exp_sig  = 14'b00_0001_1000_1111;
        exp_done = 14'b00_0010_0001_0000;
`else
        exp_sig  = 14'b00_0000_0000_1111;
        exp_done = 14'b00_0000_0001_0000;
`endif
        for (int j = 0; j < 14; j++) begin
            start_i = (j == 0 || j == 2 || j == 3);
            len_i   = (j == 0) ? 8'd4 : (j == 2) ? 8'd6 : 8'd2;
            gap_i   = (j == 0) ? 8'd2 : (j == 2) ? 8'd5 : 8'd1;
            step();
            n_chk++; if (signal_o !== exp_sig[j]) begin n_fail++; $display("FAIL busy_start_signal j=%0d got=%b exp=%b", j+1, signal_o, exp_sig[j]); end
            n_chk++; if (done_o !== exp_done[j]) begin n_fail++; $display("FAIL busy_start_done j=%0d got=%b exp=%b", j+1, done_o, exp_done[j]); end
        end
        start_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; len_i = '0; gap_i = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_held_start();
        test_rst_mid();
        test_max();
        test_busy_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
